// File: rtl/lcd_fb_writer.sv
// Streams LCD pixels into a framebuffer write port, addressing by running counter.
// Define LCD_FB_WRITER_CLEAR_EN to blank the framebuffer to 2'b00 after every reset.
module lcd_fb_writer #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 144
) (
  input  logic        clk_100mhz,
  input  logic        rst,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic [1:0]  pix_data,
  output logic [14:0] addra,
  output logic [1:0]  dina,
  output logic        wea,
  output logic        frame_done,
  output logic        sync_err,
  output logic        busy
);

  localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] XMax     = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMax     = YW'(HEIGHT - 1);
  localparam logic [14:0]   AddrLast = 15'(WIDTH * HEIGHT - 1);

`ifdef LCD_FB_WRITER_CLEAR_EN
  typedef enum logic [1:0] {StIdle, StActive, StClear} state_e;
  localparam state_e StReset = StClear;
`else
  typedef enum logic [1:0] {StIdle, StActive} state_e;
  localparam state_e StReset = StIdle;
`endif

  state_e        r_state, w_state_next;
  logic [XW-1:0] r_x, w_x_next, w_cur_x;
  logic [YW-1:0] r_y, w_y_next, w_cur_y;
  logic [14:0]   r_addr, w_addr_next, w_cur_addr;
  logic [14:0]   r_addra, w_addra_next;
  logic [1:0]    r_dina, w_dina_next;
  logic          r_wea, w_wea_next;
  logic          r_done, w_done_next;
  logic          r_err, w_err_next;
  logic          w_acc;

  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_y_next     = r_y;
    w_addr_next  = r_addr;
    w_addra_next = r_addra;
    w_dina_next  = r_dina;
    w_wea_next   = 1'b0;
    w_done_next  = 1'b0;
    w_err_next   = r_err;
    w_acc        = 1'b0;
    // A start-of-frame pixel always lands at the origin, whatever the counters say.
    w_cur_x      = pix_sof ? '0 : r_x;
    w_cur_y      = pix_sof ? '0 : r_y;
    w_cur_addr   = pix_sof ? '0 : r_addr;

    case (r_state)
      StIdle: w_acc = pix_valid & pix_sof;
      StActive: begin
        w_acc = pix_valid;
        if (pix_valid && pix_sof && (r_x != '0 || r_y != '0)) begin
          w_err_next = 1'b1;
        end
      end
`ifdef LCD_FB_WRITER_CLEAR_EN
      StClear: begin
        w_wea_next   = 1'b1;
        w_addra_next = r_addr;
        w_dina_next  = 2'b00;
        if (r_addr == AddrLast) begin
          w_state_next = StIdle;
          w_addr_next  = '0;
        end else begin
          w_addr_next = r_addr + 15'd1;
        end
      end
`endif
      default: w_state_next = StIdle;
    endcase

    if (w_acc) begin
      w_wea_next   = 1'b1;
      w_addra_next = w_cur_addr;
      w_dina_next  = pix_data;
      if (w_cur_x == XMax && w_cur_y == YMax) begin
        w_state_next = StIdle;
        w_x_next     = '0;
        w_y_next     = '0;
        w_addr_next  = '0;
        w_done_next  = 1'b1;
      end else begin
        w_state_next = StActive;
        w_addr_next  = w_cur_addr + 15'd1;
        if (w_cur_x == XMax) begin
          w_x_next = '0;
          w_y_next = w_cur_y + YW'(1);
        end else begin
          w_x_next = w_cur_x + XW'(1);
          w_y_next = w_cur_y;
        end
      end
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      r_state <= StReset;
      r_x     <= '0;
      r_y     <= '0;
      r_addr  <= '0;
      r_addra <= '0;
      r_dina  <= '0;
      r_wea   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_addr  <= w_addr_next;
      r_addra <= w_addra_next;
      r_dina  <= w_dina_next;
      r_wea   <= w_wea_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
    end
  end

  assign addra      = r_addra;
  assign dina       = r_dina;
  assign wea        = r_wea;
  assign frame_done = r_done;
  assign sync_err   = r_err;
  assign busy       = (r_state != StIdle);

endmodule
